// File: rtl/alu_func_unit.sv
// rtl/alu_func_unit.sv - RV32I integer ALU execution unit with CDB req/grant broadcast

package tomasula_types;

    typedef enum logic [1:0] {
        REG    = 2'd0,
        IMM    = 2'd1,
        BRANCH = 2'd2
    } alu_op_t;

    typedef struct packed {
        alu_op_t     op;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] src1_data;
        logic [31:0] src2_data;
        logic [31:0] imm;
        logic [2:0]  tag;
    } alu_word;

endpackage

module alu_func_unit #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_exe,
    input  tomasula_types::alu_word alu_data,
    output logic                   alu_free,
    output logic                   cdb_req,
    input  logic                   cdb_grant,
    output logic                   cdb_valid,
    output logic [2:0]             cdb_tag,
    output logic [31:0]            cdb_data
);

    // The counter only has to hold EXEC_CYCLES-2; keep at least one bit for EXEC_CYCLES<=2.
    localparam int CNT_W = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((EXEC_CYCLES > 1) ? EXEC_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      result_q;
    logic [2:0]       tag_q;

    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [4:0]       shamt;
    logic [31:0]      result_d;

    // Operand selection and RV32I result, computed straight off the issuing word.
    always_comb begin
        op_a     = alu_data.src1_data;
        op_b     = (alu_data.op == tomasula_types::IMM) ? alu_data.imm : alu_data.src2_data;
        shamt    = op_b[4:0];
        result_d = 32'd0;
        if (alu_data.op == tomasula_types::BRANCH) begin
            case (alu_data.funct3)
                3'b000:  result_d = {31'd0, op_a == alu_data.src2_data};
                3'b001:  result_d = {31'd0, op_a != alu_data.src2_data};
                3'b100:  result_d = {31'd0, $signed(op_a) <  $signed(alu_data.src2_data)};
                3'b101:  result_d = {31'd0, $signed(op_a) >= $signed(alu_data.src2_data)};
                3'b110:  result_d = {31'd0, op_a <  alu_data.src2_data};
                3'b111:  result_d = {31'd0, op_a >= alu_data.src2_data};
                default: result_d = 32'd0;
            endcase
        end else begin
            case (alu_data.funct3)
                3'b000: begin
                    // Immediate forms have no subtract; funct7 there is just immediate bits.
                    if (alu_data.funct7 && (alu_data.op != tomasula_types::IMM))
                        result_d = op_a - op_b;
                    else
                        result_d = op_a + op_b;
                end
                3'b001:  result_d = op_a << shamt;
                3'b010:  result_d = {31'd0, $signed(op_a) < $signed(op_b)};
                3'b011:  result_d = {31'd0, op_a < op_b};
                3'b100:  result_d = op_a ^ op_b;
                3'b101: begin
                    if (alu_data.funct7)
                        result_d = $signed(op_a) >>> shamt;
                    else
                        result_d = op_a >> shamt;
                end
                3'b110:  result_d = op_a | op_b;
                default: result_d = op_a & op_b;
            endcase
        end
    end

    // Issue / latency / CDB handshake state machine with registered free and request flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            result_q <= 32'd0;
            tag_q    <= 3'd0;
            alu_free <= 1'b1;
            cdb_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_exe) begin
                        result_q <= result_d;
                        tag_q    <= alu_data.tag;
                        alu_free <= 1'b0;
                        if (EXEC_CYCLES == 1) begin
                            state   <= DONE;
                            cdb_req <= 1'b1;
                        end else begin
                            count <= CNT_INIT;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state   <= DONE;
                        cdb_req <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Without a grant the held result simply waits; outputs stay put.
                    if (cdb_grant) begin
                        state    <= IDLE;
                        cdb_req  <= 1'b0;
                        alu_free <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    alu_free <= 1'b1;
                    cdb_req  <= 1'b0;
                end
            endcase
        end
    end

    assign cdb_valid = cdb_req & cdb_grant;
    assign cdb_tag   = tag_q;
    assign cdb_data  = result_q;

endmodule

// File: tb/tb_alu_func_unit.sv
// tb/tb_alu_func_unit.sv - scoreboard bench for alu_func_unit at 1- and 3-cycle latency

module tb_alu_func_unit;
    import tomasula_types::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        start1, grant1, free1, req1, valid1;
    alu_word     data1;
    logic [2:0]  tag1;
    logic [31:0] d1;

    logic        start3, grant3, free3, req3, valid3;
    alu_word     data3;
    logic [2:0]  tag3;
    logic [31:0] d3;

    logic [34:0] q1[$];
    logic [34:0] q3[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_func_unit #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start_exe(start1), .alu_data(data1), .alu_free(free1),
        .cdb_req(req1), .cdb_grant(grant1), .cdb_valid(valid1), .cdb_tag(tag1), .cdb_data(d1)
    );

    alu_func_unit #(.EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start_exe(start3), .alu_data(data3), .alu_free(free3),
        .cdb_req(req3), .cdb_grant(grant3), .cdb_valid(valid3), .cdb_tag(tag3), .cdb_data(d3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic alu_word mk(input alu_op_t op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] s1, input logic [31:0] s2,
                                   input logic [31:0] imm, input logic [2:0] tag);
        alu_word w;
        w.op        = op;
        w.funct3    = f3;
        w.funct7    = f7;
        w.src1_data = s1;
        w.src2_data = s2;
        w.imm       = imm;
        w.tag       = tag;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [34:0] e;
        if (valid1) begin
            if (q1.size() == 0) begin
                chk("cdb1_spurious_valid", {31'd0, valid1}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("cdb1_tag", {29'd0, tag1}, {29'd0, e[34:32]});
                chk("cdb1_data", d1, e[31:0]);
            end
        end
        if (valid3) begin
            if (q3.size() == 0) begin
                chk("cdb3_spurious_valid", {31'd0, valid3}, 32'd0);
            end else begin
                e = q3.pop_front();
                chk("cdb3_tag", {29'd0, tag3}, {29'd0, e[34:32]});
                chk("cdb3_data", d3, e[31:0]);
            end
        end
    end

    // Single-cycle unit: accept at T, grant at T+1, free again at T+2.
    task automatic run1(input alu_word w, input logic [31:0] exp);
        tick();
        start1 = 1'b1;
        data1  = w;
        q1.push_back({w.tag, exp});
        @(negedge clk);
        chk("free1_accept", {31'd0, free1}, 32'd1);
        chk("req1_accept", {31'd0, req1}, 32'd0);
        tick();
        start1 = 1'b0;
        grant1 = 1'b1;
        @(negedge clk);
        chk("req1_t1", {31'd0, req1}, 32'd1);
        tick();
        grant1 = 1'b0;
        @(negedge clk);
        chk("free1_t2", {31'd0, free1}, 32'd1);
        chk("req1_t2", {31'd0, req1}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start1 = 1'b0; grant1 = 1'b0; data1 = '0;
        start3 = 1'b0; grant3 = 1'b0; data3 = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_free1", {31'd0, free1}, 32'd1);
        chk("rst_req1", {31'd0, req1}, 32'd0);
        chk("rst_valid1", {31'd0, valid1}, 32'd0);
        chk("rst_tag1", {29'd0, tag1}, 32'd0);
        chk("rst_data1", d1, 32'd0);
        chk("rst_free3", {31'd0, free3}, 32'd1);
        chk("rst_req3", {31'd0, req3}, 32'd0);
        tick();
        rst = 1'b0;

        run1(mk(REG,    3'b000, 1'b0, 32'd5,        32'd7,        32'd0,     3'd3), 32'd12);
        run1(mk(REG,    3'b101, 1'b1, 32'h80000000, 32'd4,        32'd0,     3'd1), 32'hF8000000);
        run1(mk(REG,    3'b101, 1'b0, 32'h80000000, 32'd4,        32'd0,     3'd2), 32'h08000000);
        run1(mk(IMM,    3'b000, 1'b1, 32'd10,       32'd100,      32'd4,     3'd4), 32'd14);
        run1(mk(REG,    3'b011, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,     3'd5), 32'd1);
        run1(mk(REG,    3'b010, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,     3'd6), 32'd0);
        run1(mk(IMM,    3'b001, 1'b0, 32'd1,        32'd0,        32'h23,    3'd7), 32'd8);
        run1(mk(REG,    3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,     3'd0), 32'h0FF00FF0);
        run1(mk(REG,    3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F000000, 32'd0,     3'd1), 32'hFFF0F0F0);
        run1(mk(REG,    3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,     3'd2), 32'hF000F000);
        run1(mk(REG,    3'b000, 1'b0, 32'hFFFFFFFF, 32'd2,        32'd0,     3'd3), 32'd1);
        run1(mk(BRANCH, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd5,     3'd4), 32'd1);
        run1(mk(BRANCH, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd5,     3'd5), 32'd1);
        run1(mk(BRANCH, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd5,     3'd6), 32'd0);
        run1(mk(BRANCH, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd5,     3'd7), 32'd0);
        run1(mk(BRANCH, 3'b000, 1'b0, 32'd7,        32'd7,        32'd0,     3'd1), 32'd1);
        run1(mk(BRANCH, 3'b001, 1'b0, 32'd7,        32'd7,        32'd0,     3'd2), 32'd0);
        run1(mk(BRANCH, 3'b010, 1'b0, 32'd7,        32'd7,        32'd0,     3'd3), 32'd0);

        // Three-cycle unit: SUB 3-5 tag 5, late grant, stray issues while BUSY and DONE.
        tick();
        start3 = 1'b1;
        data3  = mk(REG, 3'b000, 1'b1, 32'd3, 32'd5, 32'd0, 3'd5);
        q3.push_back({3'd5, 32'hFFFFFFFE});
        @(negedge clk);
        chk("free3_accept", {31'd0, free3}, 32'd1);
        tick();
        start3 = 1'b0;
        @(negedge clk);
        chk("req3_t1", {31'd0, req3}, 32'd0);
        chk("free3_busy", {31'd0, free3}, 32'd0);
        tick();
        start3 = 1'b1;
        data3  = mk(REG, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 3'd6);
        @(negedge clk);
        chk("req3_t2", {31'd0, req3}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            start3 = (i == 1);
            @(negedge clk);
            chk("req3_hold", {31'd0, req3}, 32'd1);
            chk("valid3_hold", {31'd0, valid3}, 32'd0);
            chk("tag3_hold", {29'd0, tag3}, 32'd5);
            chk("data3_hold", d3, 32'hFFFFFFFE);
        end
        tick();
        start3 = 1'b0;
        grant3 = 1'b1;
        @(negedge clk);
        chk("req3_grant", {31'd0, req3}, 32'd1);
        tick();
        grant3 = 1'b0;
        @(negedge clk);
        chk("valid3_after", {31'd0, valid3}, 32'd0);
        chk("free3_after", {31'd0, free3}, 32'd1);
        chk("req3_after", {31'd0, req3}, 32'd0);

        // Reset while holding a result: it must vanish without a broadcast.
        tick();
        start1 = 1'b1;
        data1  = mk(REG, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 3'd4);
        tick();
        start1 = 1'b0;
        @(negedge clk);
        chk("req1_before_rst", {31'd0, req1}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        grant1 = 1'b1;
        @(negedge clk);
        chk("free1_post_rst", {31'd0, free1}, 32'd1);
        chk("req1_post_rst", {31'd0, req1}, 32'd0);
        chk("valid1_post_rst", {31'd0, valid1}, 32'd0);
        tick();
        grant1 = 1'b0;
        @(negedge clk);
        chk("free1_idle", {31'd0, free1}, 32'd1);

        chk("q1_drained", q1.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
